// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the APB clock-control register block:
// register offsets, field bit positions and the divider-update FSM states.
package clk_ctrl_pkg;

    localparam logic [3:0] OFS_DIV    = 4'h0;
    localparam logic [3:0] OFS_CFG    = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;
    localparam logic [3:0] OFS_CMD    = 4'hC;

    localparam int CFG_TOG    = 0;
    localparam int CFG_CKEN   = 1;
    localparam int CFG_ICG    = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_DIV_LSB = 16;

    localparam int CMD_APPLY  = 0;

    typedef enum logic {
        UPD_IDLE = 1'b0,
        UPD_WAIT = 1'b1
    } upd_state_e;

    // Expand APB byte strobes into a 32-bit write mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/clk_div_upd_fsm.sv
// One channel's divider-update handshake: latches the staged divider on APPLY,
// holds req until a rising ack edge or until the wait budget runs out.
module clk_div_upd_fsm
    import clk_ctrl_pkg::*;
#(
    parameter int               DIV_W       = 4,
    parameter int               TIMEOUT_CYC = 256,
    parameter logic [DIV_W-1:0] DIV_RST     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply_i,
    input  logic             ack_i,
    input  logic [DIV_W-1:0] staged_div_i,
    output logic [DIV_W-1:0] div_o,
    output logic             req_o,
    output logic             busy_o,
    output logic             timeout_set_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    upd_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_n;
    logic             ack_q;
    logic             ack_rise;

    // Only a fresh ack edge completes a request, so a stale high ack is ignored.
    assign ack_rise = ack_i & ~ack_q;
    assign req_o    = (state == UPD_WAIT);
    assign busy_o   = (state == UPD_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UPD_IDLE;
            cnt   <= '0;
            div_o <= DIV_RST;
            ack_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            div_o <= div_n;
            ack_q <= ack_i;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        div_n         = div_o;
        timeout_set_o = 1'b0;
        case (state)
            UPD_IDLE: begin
                if (apply_i) begin
                    state_n = UPD_WAIT;
                    cnt_n   = '0;
                    div_n   = staged_div_i;
                end
            end
            UPD_WAIT: begin
                if (ack_rise) begin
                    state_n = UPD_IDLE;
                end else if (cnt == CNT_LIMIT) begin
                    state_n       = UPD_IDLE;
                    timeout_set_o = 1'b1;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = UPD_IDLE;
        endcase
    end

endmodule

// File: rtl/apb_clk_ctrl_regs.sv
// APB clock-control register slave: per-channel staged divider, config bits,
// status and APPLY command, with one divider-update FSM per channel.
module apb_clk_ctrl_regs
    import clk_ctrl_pkg::*;
#(
    parameter int                NCH         = 5,
    parameter int                DIV_W       = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0013_0000,
    parameter logic [DIV_W-1:0]  DIV_RST     = '0,
    parameter logic [2:0]        CFG_RST     = 3'b111,
    parameter int                TIMEOUT_CYC = 256
) (
    input  logic                 p_clk,
    input  logic                 p_rst,
    input  logic [ADDR_W-1:0]    paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    input  logic [3:0]           pstrb,
    output logic                 pready,
    output logic [31:0]          prdata,
    output logic                 pslverr,
    output logic [NCH*DIV_W-1:0] clk_div_o,
    output logic [NCH-1:0]       clk_tog_o,
    output logic [NCH-1:0]       clk_cken_o,
    output logic [NCH-1:0]       icg_on_o,
    output logic [NCH-1:0]       div_upd_req_o,
    input  logic [NCH-1:0]       div_upd_ack_i
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(16 * NCH);

    logic [DIV_W-1:0] stg_div [NCH];
    logic [DIV_W-1:0] act_div [NCH];
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   timeout;
    logic [NCH-1:0]   tout_set;
    logic [NCH-1:0]   apply;
    logic [NCH-1:0]   tout_clr;

    logic              access;
    logic [ADDR_W-1:0] off;
    logic              addr_ok;
    logic [CH_W-1:0]   ch;
    logic [3:0]        reg_ofs;
    logic              ch_busy;
    logic              err;
    logic              wr_ok;
    logic [31:0]       rdata;
    logic [31:0]       div_merge;
    logic              unused_div_bits;

    assign access  = psel & penable;
    assign off     = paddr - BASE_ADDR;
    assign addr_ok = (paddr >= BASE_ADDR) && (off < SPAN) && (paddr[1:0] == 2'b00);
    assign ch      = off[4 +: CH_W];
    assign reg_ofs = off[3:0];
    assign ch_busy = addr_ok & busy[ch];

    // The staged divider and the APPLY command are locked while a handshake is open.
    assign err = ~addr_ok
               | (pwrite & ch_busy & ((reg_ofs == OFS_DIV) |
                                      ((reg_ofs == OFS_CMD) & pwdata[CMD_APPLY])));

    assign pready  = 1'b1;
    assign pslverr = access & err;
    assign wr_ok   = access & pwrite & ~err;

    assign div_merge = ({{(32-DIV_W){1'b0}}, stg_div[ch]} & ~strb_mask(pstrb))
                     | (pwdata & strb_mask(pstrb));
    assign unused_div_bits = ^div_merge[31:DIV_W];

    always_comb begin
        rdata = '0;
        case (reg_ofs)
            OFS_DIV: rdata[DIV_W-1:0] = stg_div[ch];
            OFS_CFG: begin
                rdata[CFG_TOG]  = clk_tog_o[ch];
                rdata[CFG_CKEN] = clk_cken_o[ch];
                rdata[CFG_ICG]  = icg_on_o[ch];
            end
            OFS_STATUS: begin
                rdata[ST_BUSY]             = busy[ch];
                rdata[ST_TIMEOUT]          = timeout[ch];
                rdata[ST_DIV_LSB +: DIV_W] = act_div[ch];
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            prdata     <= '0;
            timeout    <= '0;
            clk_tog_o  <= {NCH{CFG_RST[CFG_TOG]}};
            clk_cken_o <= {NCH{CFG_RST[CFG_CKEN]}};
            icg_on_o   <= {NCH{CFG_RST[CFG_ICG]}};
            for (int c = 0; c < NCH; c++) stg_div[c] <= DIV_RST;
        end else begin
            // A new timeout in the same cycle as its clear stays visible.
            timeout <= (timeout & ~tout_clr) | tout_set;
            if (access) prdata <= (~pwrite & ~err) ? rdata : '0;
            if (wr_ok) begin
                case (reg_ofs)
                    OFS_DIV: stg_div[ch] <= div_merge[DIV_W-1:0];
                    OFS_CFG: begin
                        if (pstrb[0]) begin
                            clk_tog_o[ch]  <= pwdata[CFG_TOG];
                            clk_cken_o[ch] <= pwdata[CFG_CKEN];
                            icg_on_o[ch]   <= pwdata[CFG_ICG];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic ch_hit;
        assign ch_hit      = wr_ok & (ch == CH_W'(c));
        assign apply[c]    = ch_hit & (reg_ofs == OFS_CMD) & pwdata[CMD_APPLY];
        assign tout_clr[c] = ch_hit & (reg_ofs == OFS_STATUS) & pwdata[ST_TIMEOUT];

        clk_div_upd_fsm #(
            .DIV_W       (DIV_W),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .DIV_RST     (DIV_RST)
        ) u_fsm (
            .clk           (p_clk),
            .rst           (p_rst),
            .apply_i       (apply[c]),
            .ack_i         (div_upd_ack_i[c]),
            .staged_div_i  (stg_div[c]),
            .div_o         (act_div[c]),
            .req_o         (div_upd_req_o[c]),
            .busy_o        (busy[c]),
            .timeout_set_o (tout_set[c])
        );

        assign clk_div_o[c*DIV_W +: DIV_W] = act_div[c];
    end

endmodule

// File: tb/tb_apb_clk_ctrl_regs.sv
// Bench for apb_clk_ctrl_regs: directed APB traffic with expected responses
// queued by the driver and compared by an independent bus monitor.
module tb_apb_clk_ctrl_regs;

    localparam int NCH = 5;
    localparam int DIV_W = 4;
    localparam int TO = 8;
    localparam logic [31:0] B = 32'h0013_0000;

    logic                 p_clk = 1'b0;
    logic                 p_rst;
    logic [31:0]          paddr;
    logic                 psel, penable, pwrite;
    logic [31:0]          pwdata;
    logic [3:0]           pstrb;
    logic                 pready;
    logic [31:0]          prdata;
    logic                 pslverr;
    logic [NCH*DIV_W-1:0] clk_div_o;
    logic [NCH-1:0]       clk_tog_o, clk_cken_o, icg_on_o, req, ack;

    int n_checks = 0;
    int n_pass = 0;
    logic [32:0] exp_q[$];

    apb_clk_ctrl_regs #(
        .NCH(NCH), .DIV_W(DIV_W), .ADDR_W(32), .BASE_ADDR(B),
        .DIV_RST('0), .CFG_RST(3'b111), .TIMEOUT_CYC(TO)
    ) dut (
        .p_clk(p_clk), .p_rst(p_rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .clk_div_o(clk_div_o),
        .clk_tog_o(clk_tog_o), .clk_cken_o(clk_cken_o), .icg_on_o(icg_on_o),
        .div_upd_req_o(req), .div_upd_ack_i(ack)
    );

    always #5 p_clk = ~p_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Monitor: latch pslverr in the access phase, compare prdata after the access edge.
    logic pend = 1'b0;
    logic err_s;
    logic [32:0] e;
    always @(negedge p_clk) begin
        if (pend) begin
            pend = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL apb_rsp unexpected response err=%0b rd=%h", err_s, prdata);
            end else begin
                e = exp_q.pop_front();
                if ({err_s, prdata} === e) n_pass++;
                else $display("FAIL apb_rsp got err=%0b rd=%h exp err=%0b rd=%h",
                              err_s, prdata, e[32], e[31:0]);
            end
        end
        if (psel && penable) begin
            pend  = 1'b1;
            err_s = pslverr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge p_clk);
        #1;
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic err, input logic [31:0] rd);
        exp_q.push_back({err, (wr || err) ? 32'h0 : rd});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge p_clk); #1 penable = 1'b1;
        @(posedge p_clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic err);
        apb(1'b1, addr, data, 4'hF, err, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        apb(1'b0, addr, 32'h0, 4'h0, 1'b0, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        p_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; ack = '0;
        cyc(3);
        p_rst = 1'b0;

        // Reset state
        chk("rst_div", 32'(clk_div_o), 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_pready", 32'(pready), 32'h1);
        chk("rst_cfg_out", 32'({icg_on_o, clk_cken_o, clk_tog_o}), 32'h7FFF);
        chk("rst_prdata", prdata, 32'h0);
        rd(B + 32'h04, 32'h7);
        rd(B + 32'h00, 32'h0);
        rd(B + 32'h08, 32'h0);

        // ch2 divider update completed by ack
        wr(B + 32'h20, 32'h9, 1'b0);
        rd(B + 32'h20, 32'h9);
        chk("div_pre_apply", 32'(clk_div_o), 32'h0);
        wr(B + 32'h2C, 32'h1, 1'b0);
        chk("apply_div", 32'(clk_div_o), 32'h00900);
        chk("apply_req", 32'(req), 32'h04);
        rd(B + 32'h28, 32'h0009_0001);
        ack[2] = 1'b1;
        chk("req_before_ack", 32'(req), 32'h04);
        cyc(1);
        chk("req_after_ack", 32'(req), 32'h0);
        ack[2] = 1'b0;
        rd(B + 32'h28, 32'h0009_0000);

        // ch1 timeout, with locked-register errors while busy
        wr(B + 32'h10, 32'h5, 1'b0);
        wr(B + 32'h1C, 32'h1, 1'b0);
        chk("to_req_up", 32'(req), 32'h02);
        wr(B + 32'h10, 32'hA, 1'b1);
        wr(B + 32'h1C, 32'h1, 1'b1);
        rd(B + 32'h10, 32'h5);
        cyc(1);
        chk("req_before_to", 32'(req[1]), 32'h1);
        cyc(1);
        chk("req_after_to", 32'(req[1]), 32'h0);
        rd(B + 32'h18, 32'h0005_0002);
        chk("div_kept", 32'(clk_div_o), 32'h00950);
        wr(B + 32'h18, 32'h2, 1'b0);
        rd(B + 32'h18, 32'h0005_0000);

        // Address errors and write-only CMD readback
        apb(1'b0, B + 32'h50, 32'h0, 4'h0, 1'b1, 32'h0);
        wr(B + 32'h54, 32'h1, 1'b1);
        apb(1'b0, B + 32'h01, 32'h0, 4'h0, 1'b1, 32'h0);
        apb(1'b0, B - 32'h4, 32'h0, 4'h0, 1'b1, 32'h0);
        rd(B + 32'h0C, 32'h0);

        // Byte strobes on CFG and DIV
        apb(1'b1, B + 32'h04, 32'h0, 4'b0000, 1'b0, 32'h0);
        rd(B + 32'h04, 32'h7);
        apb(1'b1, B + 32'h04, 32'h0, 4'b0001, 1'b0, 32'h0);
        chk("cfg_tog", 32'(clk_tog_o), 32'h1E);
        chk("cfg_cken", 32'(clk_cken_o), 32'h1E);
        chk("cfg_icg", 32'(icg_on_o), 32'h1E);
        rd(B + 32'h04, 32'h0);
        apb(1'b1, B + 32'h40, 32'hF, 4'b0000, 1'b0, 32'h0);
        rd(B + 32'h40, 32'h0);

        // ch4: ack and timeout limit in the same cycle -> ack wins
        wr(B + 32'h40, 32'h3, 1'b0);
        wr(B + 32'h4C, 32'h1, 1'b0);
        cyc(7);
        ack[4] = 1'b1;
        cyc(1);
        chk("ack_wins_req", 32'(req[4]), 32'h0);
        rd(B + 32'h48, 32'h0003_0000);

        // ch4: ack already high at APPLY needs a fresh rising edge
        wr(B + 32'h4C, 32'h1, 1'b0);
        cyc(3);
        chk("stale_ack_req", 32'(req[4]), 32'h1);
        ack[4] = 1'b0;
        cyc(1);
        ack[4] = 1'b1;
        cyc(1);
        chk("fresh_ack_req", 32'(req[4]), 32'h0);
        ack[4] = 1'b0;

        // Reset in the middle of a ch3 handshake
        wr(B + 32'h30, 32'hC, 1'b0);
        wr(B + 32'h3C, 32'h1, 1'b0);
        chk("ch3_div", 32'(clk_div_o), 32'h3C950);
        rd(B + 32'h30, 32'hC);
        p_rst = 1'b1;
        cyc(1);
        p_rst = 1'b0;
        chk("mid_rst_req", 32'(req), 32'h0);
        chk("mid_rst_div", 32'(clk_div_o), 32'h0);
        chk("mid_rst_prdata", prdata, 32'h0);
        chk("mid_rst_cfg", 32'({icg_on_o, clk_cken_o, clk_tog_o}), 32'h7FFF);
        rd(B + 32'h38, 32'h0);
        rd(B + 32'h30, 32'h0);

        for (int i = 0; i < 20 && (exp_q.size() > 0 || pend); i++) @(posedge p_clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain got=%0d responses left exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
